// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   XLEN_DEFAULT : default operand/result width
//   ALU_CTRL_W   : width of the alu_ctrl code
//   alu_ctrl_e   : ALU control codes driven onto alu.alu_ctrl
//   rsp_state_e  : response-register occupancy state
package alu_share_arbiter_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int ALU_CTRL_W   = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_ctrl_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin priority picker, purely combinational.
//   req_i : request vector, one bit per requester
//   ptr_i : highest-priority index this cycle (always < NREQ)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester
//   any_o : at least one request was granted
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic found;

  // Two ascending passes: indices at/after the pointer first, then the
  // wrapped-around indices below it. The first hit in that order wins.
  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (IDW'(i) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (IDW'(i) < ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares a single combinational ALU between NREQ requesters.
// Round-robin grant with an optional per-op lock, valid/ready handshakes on
// both sides, and a one-entry response register (latency 1).
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/lock/in1/in2/ctrl : per-requester op (fields packed by index)
//   req_ready                : one-hot (or zero) accept strobe
//   alu_in1/in2/ctrl         : operands/control to the ALU, zero when idle
//   alu_result/zero          : combinational ALU outputs
//   rsp_valid/id/result/zero : registered response, rsp_ready to drain it
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEFAULT,
  parameter int IDW  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [NREQ*XLEN-1:0]       req_in1,
  input  logic [NREQ*XLEN-1:0]       req_in2,
  input  logic [NREQ*ALU_CTRL_W-1:0] req_ctrl,
  output logic [NREQ-1:0]            req_ready,
  output logic [XLEN-1:0]            alu_in1,
  output logic [XLEN-1:0]            alu_in2,
  output logic [ALU_CTRL_W-1:0]      alu_ctrl,
  input  logic [XLEN-1:0]            alu_result,
  input  logic                       alu_zero,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [XLEN-1:0]            rsp_result,
  output logic                       rsp_zero,
  input  logic                       rsp_ready
);

  rsp_state_e      state_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            lock_valid_q;
  logic [IDW-1:0]  lock_id_q;

  logic            can_accept;
  logic            lock_hit;
  logic [NREQ-1:0] rr_gnt;
  logic [IDW-1:0]  rr_idx;
  logic            rr_any;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;

  assign rsp_valid  = (state_q == ST_FULL);
  // Draining and refilling in the same cycle keeps full throughput.
  assign can_accept = !rsp_valid || rsp_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // Locked owner still requesting; a loop compare avoids indexing req_valid
  // with an id wider than the vector needs.
  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (lock_valid_q && req_valid[i] && (lock_id_q == IDW'(i))) lock_hit = 1'b1;
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst && can_accept) begin
      if (lock_hit) begin
        for (int i = 0; i < NREQ; i++) gnt[i] = (lock_id_q == IDW'(i));
        gnt_idx = lock_id_q;
        gnt_any = 1'b1;
      end else begin
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
        gnt_any = rr_any;
      end
    end
  end

  assign req_ready = gnt;

  // Operand mux; an idle cycle drives all-zero operands and ctrl 4'b0000.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_in1  = req_in1[i*XLEN +: XLEN];
        alu_in2  = req_in2[i*XLEN +: XLEN];
        alu_ctrl = req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
      end
    end
  end

  assign ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
    end else begin
      if (gnt_any) begin
        rsp_id       <= gnt_idx;
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        ptr_q        <= ptr_d;
        lock_valid_q <= |(req_lock & gnt);
        lock_id_q    <= gnt_idx;
      end else if (can_accept && lock_valid_q && !lock_hit) begin
        lock_valid_q <= 1'b0;
      end

      case (state_q)
        ST_EMPTY: if (gnt_any)                state_q <= ST_FULL;
        ST_FULL:  if (rsp_ready && !gnt_any) state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule
